// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: MULT/MULTU take 5 cycles and DIV/DIVU take 10.
// MTHI/MTLO write HI/LO directly. Operands are captured when an operation is accepted.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        we,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        uns_q;

  logic [63:0] ext_a, ext_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, dvs, uq, ur, quo, rem;

  assign stall = busy | (start & ~op[2]);

  // Sign/zero-extend to 64 bits, so one modular multiply serves both MULT and MULTU.
  always_comb begin
    ext_a = uns_q ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
    ext_b = uns_q ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
    prod  = ext_a * ext_b;
  end

  // Signed division runs on magnitudes and then fixes the signs. The divisor is
  // forced nonzero here because a zero divisor never writes HI/LO.
  always_comb begin
    neg_a = ~uns_q & a_q[31];
    neg_b = ~uns_q & b_q[31];
    mag_a = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b = neg_b ? (~b_q + 32'd1) : b_q;
    dvs   = (mag_b == '0) ? 32'd1 : mag_b;
    uq    = mag_a / dvs;
    ur    = mag_a % dvs;
    quo   = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem   = neg_a ? (~ur + 32'd1) : ur;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      uns_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              a_q   <= rs_e;
              b_q   <= rt_e;
              uns_q <= op[0];
              cnt   <= op[1] ? 4'd10 : 4'd5;
              state <= op[1] ? DIV : MUL;
              busy  <= 1'b1;
            end
          end else if (we) begin
            if (op == 3'd4) hi <= rs_e;
            if (op == 3'd5) lo <= rs_e;
          end
        end
        MUL, DIV: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (state == MUL) begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end else if (b_q != '0) begin
              hi <= rem;
              lo <= quo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a table of arithmetic vectors plus hand-written
// sequences for MTHI/MTLO, divide by zero, ignored requests and mid-operation reset.
`timescale 1ns/1ps
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        we = 1'b0;
  logic [31:0] rs_e = '0;
  logic [31:0] rt_e = '0;
  logic [31:0] hi, lo;
  logic        busy, stall;

  int unsigned total = 0;
  int unsigned bad = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .we(we),
    .rs_e(rs_e), .rt_e(rt_e), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch one operation at a negedge, then scramble the operands once it is
  // accepted. Returns the number of sampled cycles during which busy was high.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int unsigned busy_cycles);
    @(negedge clk);
    start = 1'b1; op = o; rs_e = a; rt_e = b;
    #1 chk("stall_on_start", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'd7; rs_e = 32'hDEADBEEF; rt_e = 32'h0BADF00D;
    busy_cycles = 0;
    @(negedge clk);
    while (busy && busy_cycles < 30) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic write_hilo(input logic [2:0] o, input logic [31:0] v);
    @(negedge clk);
    we = 1'b1; op = o; rs_e = v;
    @(negedge clk);
    we = 1'b0; op = 3'd7;
  endtask

  initial begin
    int unsigned nb;
    logic [31:0] h0, l0;

    vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[6]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[7]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[9]  = '{3'd0, 32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE};
    vecs[10] = '{3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

    // Reset state
    #12;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    start = 1'b1; op = 3'd2; #1;
    chk("reset_stall", {31'b0, stall}, 32'd1);
    start = 1'b0; #1;
    chk("reset_stall_idle", {31'b0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, nb);
      chk($sformatf("v%0d_busy_cycles", i), nb, (vecs[i].op[1] ? 32'd10 : 32'd5));
      chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // MTHI/MTLO, then divide by zero leaves HI/LO untouched
    write_hilo(3'd4, 32'h12345678);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    write_hilo(3'd5, 32'hCAFEF00D);
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    run_op(3'd2, 32'h00000064, 32'h00000000, nb);
    chk("div0_busy_cycles", nb, 32'd10);
    chk("div0_hi", hi, 32'h12345678);
    chk("div0_lo", lo, 32'hCAFEF00D);

    // No-op requests: start with op 6 and we with op 7
    @(negedge clk);
    start = 1'b1; op = 3'd6; rs_e = 32'h11111111; #1;
    chk("noop_start_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; we = 1'b1; op = 3'd7;
    @(negedge clk);
    we = 1'b0;
    chk("noop_busy", {31'b0, busy}, 32'd0);
    chk("noop_hi", hi, 32'h12345678);
    chk("noop_lo", lo, 32'hCAFEF00D);

    // start takes priority over a simultaneous write in IDLE
    @(negedge clk);
    start = 1'b1; we = 1'b1; op = 3'd4; rs_e = 32'h22222222;
    @(negedge clk);
    start = 1'b0; we = 1'b0; op = 3'd7;
    chk("prio_hi", hi, 32'h12345678);

    // Requests during a MULT are ignored and stall stays high throughout busy
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs_e = 32'h00000006; rt_e = 32'h00000007;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    @(negedge clk);
    start = 1'b1; we = 1'b1; op = 3'd5; rs_e = 32'h99999999; rt_e = 32'h5;
    #1 chk("ign_stall_mid", {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b1; we = 1'b0; op = 3'd1; rs_e = 32'hFFFFFFFF; rt_e = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    chk("ign_stall_busy", {31'b0, stall & busy}, 32'd1);
    chk("ign_lo_before", lo, 32'hCAFEF00D);
    @(negedge clk);
    chk("ign_busy_last", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("ign_busy_done", {31'b0, busy}, 32'd0);
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'd42);

    // Reset at cycle 3 of a MULT aborts it; no late write
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs_e = 32'h00001000; rt_e = 32'h00001000;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    h0 = hi; l0 = lo;
    repeat (6) @(negedge clk);
    chk("rst_nowrite_hi", hi, 32'h0);
    chk("rst_nowrite_lo", lo, 32'h0);
    chk("rst_nowrite_busy", {31'b0, busy}, 32'd0);

    // First start after reset release is accepted at the first edge
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1; op = 3'd3; rs_e = 32'd100; rt_e = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd7;
    chk("post_rst_busy", {31'b0, busy}, 32'd1);
    nb = 0;
    @(negedge clk);
    while (busy && nb < 30) begin
      nb++;
      @(negedge clk);
    end
    chk("post_rst_cycles", nb, 32'd10);
    chk("post_rst_hi", hi, 32'd2);
    chk("post_rst_lo", lo, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 ns");
    $fatal(1);
  end

endmodule
